// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder (package dmem_pkg).
// The optional access counters are enabled with the DMEM_ACCESS_COUNT_EN macro.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WAIT_CNT_WIDTH = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int COUNT_WIDTH    = 16;

    // True when no bit above the implemented word-index field is set.
    function automatic logic addr_in_range(input logic [DATA_WIDTH-1:0] addr,
                                           input int unsigned           aw);
        logic [DATA_WIDTH-1:0] hi;
        hi = addr >> aw;
        return (hi == {DATA_WIDTH{1'b0}});
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == {COUNT_WIDTH{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Core-to-data-memory bus: request, address, data and the Ready/AccessError completion.
interface data_memory_responder_if;
    import dmem_pkg::*;

    logic                  MemRead;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] Address_DataMem;
    logic [DATA_WIDTH-1:0] WriteData_DataMem;
    logic [DATA_WIDTH-1:0] ReadData_DataMem;
    logic                  Ready;
    logic                  AccessError;

    modport master (
        output MemRead, MemWrite, Address_DataMem, WriteData_DataMem,
        input  ReadData_DataMem, Ready, AccessError
    );

    modport slave (
        input  MemRead, MemWrite, Address_DataMem, WriteData_DataMem,
        output ReadData_DataMem, Ready, AccessError
    );
endinterface

// File: rtl/data_memory_responder_dmem_array.sv
// Single-port synchronous RAM with registered read data; the read register can be
// cleared so an illegal completion reports zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Storage array: no reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read-data next value.
    always_comb begin
        rdata_d = rdata_q;
        if (clr) begin
            rdata_d = {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_d = mem_q[addr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Word-addressed data-memory responder with a Ready handshake and WAIT_STATES latency.
// Define DMEM_ACCESS_COUNT_EN to add saturating ReadCount/WriteCount outputs.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    data_memory_responder_if.slave  bus
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0]  ReadCount,
    output logic [COUNT_WIDTH-1:0]  WriteCount
`endif
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_INIT = WAIT_CNT_WIDTH'(WAIT_STATES);
    localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE   = WAIT_CNT_WIDTH'(1);

    state_e                    state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      rd_q, rd_d, wr_q, wr_d, bad_q, bad_d;
    logic                      ready_q, ready_d, err_q, err_d;

    logic                      req_s, in_bad_s, complete_s;
    logic                      cur_rd_s, cur_wr_s, cur_bad_s;
    logic [ADDR_WIDTH-1:0]     cur_addr_s;
    logic [DATA_WIDTH-1:0]     cur_wdata_s;
    logic                      ram_we_s, ram_re_s, ram_clr_s;
    logic [DATA_WIDTH-1:0]     ram_rdata_s;

    // Request decode; with zero wait states the access completes on the sampling
    // edge, so the RAM sees the live bus in IDLE and the latched copy afterwards.
    always_comb begin
        req_s    = bus.MemRead | bus.MemWrite;
        in_bad_s = ~addr_in_range(bus.Address_DataMem, ADDR_WIDTH) |
                   (bus.MemRead & bus.MemWrite);
        if (state_q == IDLE) begin
            cur_rd_s    = bus.MemRead;
            cur_wr_s    = bus.MemWrite;
            cur_bad_s   = in_bad_s;
            cur_addr_s  = bus.Address_DataMem[ADDR_WIDTH-1:0];
            cur_wdata_s = bus.WriteData_DataMem;
        end else begin
            cur_rd_s    = rd_q;
            cur_wr_s    = wr_q;
            cur_bad_s   = bad_q;
            cur_addr_s  = addr_q;
            cur_wdata_s = wdata_q;
        end
    end

    // FSM next state, wait counter and request capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        bad_d      = bad_q;
        complete_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    addr_d  = bus.Address_DataMem[ADDR_WIDTH-1:0];
                    wdata_d = bus.WriteData_DataMem;
                    rd_d    = bus.MemRead;
                    wr_d    = bus.MemWrite;
                    bad_d   = in_bad_s;
                    if (WAIT_STATES == 0) begin
                        state_d    = DONE;
                        complete_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d    = DONE;
                    complete_s = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion actions: RAM strobe, read clear and the next-cycle Ready/AccessError.
    always_comb begin
        ram_we_s  = complete_s & ~cur_bad_s & cur_wr_s;
        ram_re_s  = complete_s & ~cur_bad_s & cur_rd_s;
        ram_clr_s = complete_s & cur_bad_s;
        ready_d   = complete_s;
        err_d     = complete_s & cur_bad_s;
    end

    // State, capture and output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= {WAIT_CNT_WIDTH{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (Clock),
        .rst_n (Reset),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .clr   (ram_clr_s),
        .addr  (cur_addr_s),
        .wdata (cur_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign bus.ReadData_DataMem = ram_rdata_s;
    assign bus.Ready            = ready_q;
    assign bus.AccessError      = err_q;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [COUNT_WIDTH-1:0] read_count_q, read_count_d;
    logic [COUNT_WIDTH-1:0] write_count_q, write_count_d;

    // Only legal completions are counted.
    always_comb begin
        read_count_d  = ram_re_s ? sat_inc(read_count_q)  : read_count_q;
        write_count_d = ram_we_s ? sat_inc(write_count_q) : write_count_q;
    end

    // Access counter registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            read_count_q  <= {COUNT_WIDTH{1'b0}};
            write_count_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign ReadCount  = read_count_q;
    assign WriteCount = write_count_q;
`endif

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Word-addressed data-memory responder; the target end of the core's data-memory interface (MemRead, MemWrite, Address_DataMem, WriteData_DataMem, ReadData_DataMem).
- Adds a Ready handshake with a configurable number of wait states, so stalling core variants can be built and tested against realistic memory latency.
- Holds the data RAM and flags accesses outside the implemented range.

Parameters:
ADDR_WIDTH, 8, number of word-index bits; memory depth is 2**ADDR_WIDTH 32-bit words.
WAIT_STATES, 1, extra cycles before completion; legal range 0..15.

Ports:
Clock  input  1  single clock; all state updates on posedge.
Reset  input  1  asynchronous, active-low reset (asserted at 0).
MemRead  input  1  read request.
MemWrite  input  1  write request.
Address_DataMem  input  32  word address, not byte address.
WriteData_DataMem  input  32  write data.
ReadData_DataMem  output  32  read data; holds the last completed read.
Ready  output  1  one-cycle completion pulse.
AccessError  output  1  high together with Ready when the completing access was illegal.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE and the wait counter clears.
  - ReadData_DataMem=0, Ready=0, AccessError=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - At a posedge with MemRead|MemWrite=1, latch address, write data and op.
  - If WAIT_STATES=0, go to DONE. Otherwise go to WAIT with counter=WAIT_STATES.
  - Request inputs are ignored outside IDLE.
- WAIT:
  - Decrement the counter at each posedge.
  - When the counter is 1, the next edge goes to DONE.
- Completion edge (the edge entering DONE):
  - Legal write: RAM[addr[ADDR_WIDTH-1:0]] <= latched data.
  - Legal read: ReadData_DataMem <= RAM word.
- DONE:
  - Ready=1 for exactly one cycle, then unconditionally back to IDLE.
  - The requester must drop its request after seeing Ready. A request still held in the IDLE cycle is treated as a new access.
- Latency: a request sampled at edge T completes at edge T+WAIT_STATES. Ready is high in the following cycle, so minimum back-to-back spacing is WAIT_STATES+2 cycles.
- Illegal accesses (no RAM write; ReadData_DataMem <= 0; AccessError=1 during the DONE cycle):
  - Address[31:ADDR_WIDTH] is nonzero (out of range).
  - MemRead and MemWrite are both 1.
- Legal completion: AccessError=0.
- Reset mid-operation (WAIT or DONE): the access is abandoned. A write not yet committed is never committed, and Ready is not pulsed.
- A read of a word written at the immediately preceding completion returns the new data (no stale-read hazard; accesses are serialised by the FSM).

Optional Feature:
Macro DMEM_ACCESS_COUNT_EN.
- Defined:
  - Adds output ports ReadCount[15:0] and WriteCount[15:0].
  - Each increments on a legal completed read or write respectively and saturates at 16'hFFFF.
  - Both clear on Reset; illegal accesses are not counted.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - State enum (IDLE, WAIT, DONE).
  - WAIT_CNT_WIDTH=4.
  - Data width constant 32.
  - Count width constant 16.
- One sub-module, dmem_array: single-port synchronous RAM with write enable, registered read, depth 2**ADDR_WIDTH.
- FSM, counter, range check and error logic stay in data_memory_responder.

Test Plan:
- Reset: hold Reset=0 while driving requests -> ReadData_DataMem=0, Ready=0, AccessError=0. Release -> outputs stay 0 with no request.
- WAIT_STATES=2:
  - MemWrite, addr 5, data 32'hDEADBEEF sampled at edge T -> Ready high only in the cycle after edge T+2, AccessError=0.
  - A subsequent MemRead of addr 5 -> ReadData_DataMem=32'hDEADBEEF with the same timing.
- Out of range (ADDR_WIDTH=8): MemWrite to addr 32'h100 with data 1 -> Ready with AccessError=1. A read of addr 0 then returns its prior value, not 1.
- Both MemRead and MemWrite high at addr 3 -> AccessError=1, ReadData_DataMem=0, RAM[3] unchanged.
- Reset pulsed during WAIT of a write to addr 7 (data 32'h55) -> no Ready pulse, FSM in IDLE, a later read of addr 7 returns the old value.
- WAIT_STATES=0 with DMEM_ACCESS_COUNT_EN:
  - 3 legal writes and 2 legal reads -> Ready one cycle after each sampled request; WriteCount=3, ReadCount=2.
  - Forcing a count to 16'hFFFF and adding one more access -> count stays 16'hFFFF.
